// File: rtl/asu_riscv_mult_iter_if.sv
// Handshake and data bundle between the execute stage and the iterative multiplier.
// master: issuing side (drives request, kill); slave: multiplier (drives ready, result).
// Interface XLEN must match the XLEN of the multiplier it connects to.
interface asu_riscv_mult_iter_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      operator_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            kill_i;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, operator_i, op_a_i, op_b_i, kill_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, operator_i, op_a_i, op_b_i, kill_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/asu_riscv_mult_iter.sv
// Iterative RISC-V MUL/MULH/MULHSU/MULHU on magnitudes, STEP multiplier bits per cycle.
// Latency: XLEN/STEP + 2 cycles from accept to valid_o; 2 cycles when an operand is zero.
// Backpressure: ready_o only in IDLE; valid_o is a one-cycle pulse with no output stall.
module asu_riscv_mult_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input logic                 clk,
  input logic                 nrst,
  asu_riscv_mult_iter_if.slave bus
);
  localparam int K  = XLEN / STEP;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] a_sh;
  logic [2*XLEN-1:0] pp;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   b_sh;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   result;
  logic [IW-1:0]     iter;
  logic              neg;
  logic              hi_sel;
  logic              valid;
  logic              accept;
  logic              sign_a;
  logic              sign_b;
  logic              last;
  logic              zero_op;

  // Operand signs follow the operator: MULHU treats both unsigned, MULHSU only b unsigned.
  assign sign_a  = bus.op_a_i[XLEN-1] & (bus.operator_i != 2'b11);
  assign sign_b  = bus.op_b_i[XLEN-1] & ~bus.operator_i[1];
  // Two's complement negate of the most negative value yields 2^(XLEN-1) as unsigned.
  assign mag_a   = sign_a ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
  assign mag_b   = sign_b ? (~bus.op_b_i + 1'b1) : bus.op_b_i;
  assign zero_op = (bus.op_a_i == '0) || (bus.op_b_i == '0);
  assign accept  = bus.valid_i & (state == IDLE) & ~bus.kill_i;
  assign last    = (iter == IW'(K - 1));

  // Multiplicand is pre-shifted each cycle, so the chunk product needs no variable shifter.
  assign pp   = a_sh * {{(2*XLEN-STEP){1'b0}}, b_sh[STEP-1:0]};
  assign prod = neg ? (~acc + 1'b1) : acc;

  assign bus.ready_o  = (state == IDLE);
  assign bus.valid_o  = valid;
  assign bus.result_o = result;

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: zero operands skip CALC; kill aborts CALC/FIX back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? FIX : CALC;
      CALC: begin
        if (bus.kill_i)  state_nxt = IDLE;
        else if (last)   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, accumulate in CALC, sign-fix and publish in FIX.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      iter   <= '0;
      neg    <= 1'b0;
      hi_sel <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          acc    <= '0;
          iter   <= '0;
          a_sh   <= {{XLEN{1'b0}}, mag_a};
          b_sh   <= mag_b;
          neg    <= sign_a ^ sign_b;
          hi_sel <= (bus.operator_i != 2'b00);
        end
        CALC: if (!bus.kill_i) begin
          acc  <= acc + pp;
          a_sh <= a_sh << STEP;
          b_sh <= b_sh >> STEP;
          iter <= iter + 1'b1;
        end
        FIX: if (!bus.kill_i) begin
          result <= hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
          valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_asu_riscv_mult_iter.sv
// Directed bench for the iterative multiplier: STEP=4 and STEP=1 instances at XLEN=32.
// Latency is counted in cycles from the accept cycle to the valid_o cycle.
// A small signed 66-bit reference model checks the random section.
module tb_asu_riscv_mult_iter;
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  asu_riscv_mult_iter_if #(.XLEN(32)) bus  ();
  asu_riscv_mult_iter_if #(.XLEN(32)) bus1 ();

  asu_riscv_mult_iter #(.XLEN(32), .STEP(4)) dut  (.clk(clk), .nrst(nrst), .bus(bus));
  asu_riscv_mult_iter #(.XLEN(32), .STEP(1)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1));

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    ea = (op != 2'b11) ? {{34{a[31]}}, a} : {34'b0, a};
    eb = (op[1] == 1'b0) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic vo(input bit sel);
    return sel ? bus1.valid_o : bus.valid_o;
  endfunction

  // Issue one op, measure accept-to-valid latency, check result and single-cycle pulse.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat,
                        input string tag);
    int lat;
    @(negedge clk);
    if (sel) begin
      bus1.valid_i = 1'b1; bus1.operator_i = op; bus1.op_a_i = a; bus1.op_b_i = b;
      check({31'b0, bus1.ready_o}, 32'd1, {tag, "_ready"});
    end else begin
      bus.valid_i = 1'b1; bus.operator_i = op; bus.op_a_i = a; bus.op_b_i = b;
      check({31'b0, bus.ready_o}, 32'd1, {tag, "_ready"});
    end
    @(posedge clk); #1;
    bus.valid_i  = 1'b0;
    bus1.valid_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!vo(sel) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check(32'(lat), 32'(exp_lat), {tag, "_latency"});
    check(sel ? bus1.result_o : bus.result_o, exp_r, {tag, "_result"});
    @(negedge clk);
    check({31'b0, vo(sel)}, 32'd0, {tag, "_pulse"});
  endtask

  initial begin
    int       lat;
    bit       seen;
    bit       changed;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.valid_i = 1'b0;  bus.kill_i = 1'b0;  bus.operator_i = 2'b00;
    bus.op_a_i  = '0;    bus.op_b_i = '0;
    bus1.valid_i = 1'b0; bus1.kill_i = 1'b0; bus1.operator_i = 2'b00;
    bus1.op_a_i  = '0;   bus1.op_b_i = '0;

    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check({31'b0, bus.ready_o},  32'd1, "rst_ready");
    check({31'b0, bus.valid_o},  32'd0, "rst_valid");
    check(bus.result_o,          32'd0, "rst_result");
    check({31'b0, bus1.ready_o}, 32'd1, "rst_ready_s1");

    // Main function: latency K+2 and hand-computed products.
    run_op(1'b0, 2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, "mul_7_m3");
    run_op(1'b1, 2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3_s1");
    run_op(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10, "mulh_min_min");
    run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, "mulhu_ones");
    run_op(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, "mulhsu_ones");
    run_op(1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 10, "mul_min_m1");

    // Early exit on zero operands.
    run_op(1'b0, 2'b10, 32'h8000_0000, 32'h0,        32'h0, 2, "early_b0");
    run_op(1'b0, 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h1, 10, "mulhu_2p32");
    run_op(1'b0, 2'b01, 32'h0,        32'hFFFF_FFFF, 32'h0, 2, "early_a0");
    run_op(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, 10, "mulhsu_m2_2p31");
    run_op(1'b0, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0, 10, "mul_2p32_lo");

    // Back-to-back: second request held valid across the first valid_o cycle.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.operator_i = 2'b00; bus.op_a_i = 32'd100; bus.op_b_i = 32'd200;
    @(posedge clk); #1;
    bus.operator_i = 2'b01; bus.op_a_i = 32'hFFFF_FFFE; bus.op_b_i = 32'd3;
    lat = 1;
    @(negedge clk);
    while (!bus.valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check(32'(lat), 32'd10, "b2b_first_latency");
    check(bus.result_o, 32'h0000_4E20, "b2b_first_result");
    check({31'b0, bus.ready_o}, 32'd1, "b2b_ready_in_valid_cycle");
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    changed = 1'b0;
    @(negedge clk);
    while (!bus.valid_o && lat < 200) begin
      if (bus.result_o !== 32'h0000_4E20) changed = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({31'b0, changed}, 32'd0, "b2b_first_held");
    check(32'(lat), 32'd10, "b2b_second_latency");
    check(bus.result_o, 32'hFFFF_FFFF, "b2b_second_result");

    // Kill in the third CALC cycle.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.operator_i = 2'b00; bus.op_a_i = 32'd3; bus.op_b_i = 32'd4;
    @(posedge clk); #1 bus.valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.kill_i = 1'b1;
    @(posedge clk); #1 bus.kill_i = 1'b0;
    @(negedge clk);
    check({31'b0, bus.ready_o}, 32'd1, "kill_ready_next");
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    check({31'b0, seen}, 32'd0, "kill_no_valid");
    check(bus.result_o, 32'hFFFF_FFFF, "kill_result_kept");

    // Kill together with valid in IDLE: nothing accepted.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.kill_i = 1'b1; bus.operator_i = 2'b00;
    bus.op_a_i = 32'd3; bus.op_b_i = 32'd5;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.kill_i = 1'b0;
    @(negedge clk);
    check({31'b0, bus.ready_o}, 32'd1, "kill_idle_no_accept");
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    check({31'b0, seen}, 32'd0, "kill_idle_no_valid");

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.operator_i = 2'b00; bus.op_a_i = 32'd2; bus.op_b_i = 32'd2;
    @(posedge clk); #1 bus.valid_i = 1'b0;
    @(posedge clk); #1 nrst = 1'b0;
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    check({31'b0, bus.valid_o}, 32'd0, "midrst_valid");
    check(bus.result_o,         32'd0, "midrst_result");
    check({31'b0, bus.ready_o}, 32'd1, "midrst_ready");
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    check({31'b0, seen}, 32'd0, "midrst_no_valid");
    run_op(1'b0, 2'b00, 32'd3, 32'd5, 32'd15, 10, "post_rst_mul_3_5");

    // Random operator/operand pairs against the reference model on both instances.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 10 == 3) ra = 32'h0;
      if (i % 10 == 7) rb = 32'h8000_0000;
      run_op(i[0], rop, ra, rb, ref_mul(rop, ra, rb),
             (ra == 0 || rb == 0) ? 2 : (i[0] ? 34 : 10), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
